// File: rtl/iu_ctrl_pkg.sv
// rtl/iu_ctrl_pkg.sv - shared state encoding, PC mux selects and strobe decode for the fetch sequencer
package iu_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_WAIT  = 3'd2,
    ST_LOAD  = 3'd3,
    ST_HOLD  = 3'd4,
    ST_REDIR = 3'd5
  } state_t;

  localparam logic [1:0] PC_SEL_INC = 2'b00;
  localparam logic [1:0] PC_SEL_JMP = 2'b01;
  localparam logic [1:0] PC_SEL_BR  = 2'b10;

  // Per-state datapath strobes; pc_sel is carried separately since it depends on the accepted redirect
  typedef struct packed {
    logic pc_ld;
    logic pc_inc;
    logic ir_ld;
    logic im_cs;
    logic im_rd;
    logic ir_valid;
    logic busy;
  } ctrl_t;

  // Encoding 11 has no mux input of its own, so it falls back to loading PC_in
  function automatic logic [1:0] norm_sel(input logic [1:0] sel);
    return (sel == 2'b11) ? PC_SEL_INC : sel;
  endfunction

  // Moore decode: the strobes a state drives for its whole duration
  function automatic ctrl_t decode_state(input state_t s);
    ctrl_t c;
    c      = '0;
    c.busy = (s != ST_IDLE);
    case (s)
      ST_FETCH, ST_WAIT: begin
        c.im_cs = 1'b1;
        c.im_rd = 1'b1;
      end
      ST_LOAD: begin
        c.im_cs  = 1'b1;
        c.im_rd  = 1'b1;
        c.ir_ld  = 1'b1;
        c.pc_inc = 1'b1;
      end
      ST_HOLD:  c.ir_valid = 1'b1;
      ST_REDIR: c.pc_ld    = 1'b1;
      default:  c.busy     = 1'b0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/iu_fetch_ctrl.sv
// rtl/iu_fetch_ctrl.sv - fetch sequencer driving PC, instruction memory and IR strobes
module iu_fetch_ctrl
  import iu_ctrl_pkg::*;
#(
  parameter int MEM_LAT = 1,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             halt,
  input  logic             ir_taken,
  input  logic             redirect,
  input  logic [1:0]       redirect_sel,
  output logic             pc_ld,
  output logic             pc_inc,
  output logic [1:0]       pc_sel,
  output logic             ir_ld,
  output logic             im_cs,
  output logic             im_rd,
  output logic             im_wr,
  output logic             ir_valid,
  output logic             busy,
  output logic [CNT_W-1:0] retired
);

  // WAIT counts down from MEM_LAT-1 and hands over to LOAD when it reaches 1
  localparam logic [2:0] LAT_INIT = 3'(MEM_LAT - 1);

  state_t           state;
  state_t           state_nxt;
  ctrl_t            ctrl_q;
  logic [1:0]       pc_sel_q;
  logic [2:0]       lat_cnt;
  logic             halt_pend;
  logic [CNT_W-1:0] retired_q;

  // Next-state selection; outputs are registered from this so they line up with the state
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start) state_nxt = ST_FETCH;
      ST_FETCH: state_nxt = (MEM_LAT == 1) ? ST_LOAD : ST_WAIT;
      ST_WAIT:  if (lat_cnt == 3'd1) state_nxt = ST_LOAD;
      ST_LOAD:  state_nxt = ST_HOLD;
      ST_HOLD: begin
        if (ir_taken) begin
          if (redirect)               state_nxt = ST_REDIR;
          else if (halt_pend || halt) state_nxt = ST_IDLE;
          else                        state_nxt = ST_FETCH;
        end
      end
      ST_REDIR: state_nxt = (halt_pend || halt) ? ST_IDLE : ST_FETCH;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // State, registered strobes, latency/retire counters and the pending-halt flag
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      ctrl_q    <= '0;
      pc_sel_q  <= PC_SEL_INC;
      lat_cnt   <= '0;
      halt_pend <= 1'b0;
      retired_q <= '0;
    end else begin
      state  <= state_nxt;
      ctrl_q <= decode_state(state_nxt);
      // pc_sel doubles as the latch for the accepted redirect selector
      pc_sel_q <= (state_nxt == ST_REDIR) ? norm_sel(redirect_sel) : PC_SEL_INC;

      if (state == ST_FETCH)
        lat_cnt <= LAT_INIT;
      else if (state == ST_WAIT)
        lat_cnt <= lat_cnt - 3'd1;

      if (state == ST_HOLD && ir_taken)
        retired_q <= retired_q + CNT_W'(1);

      // A halt seen anywhere in flight is remembered until the sequencer parks in IDLE
      if (state_nxt == ST_IDLE)
        halt_pend <= 1'b0;
      else if (state != ST_IDLE && halt)
        halt_pend <= 1'b1;
    end
  end

  assign pc_ld    = ctrl_q.pc_ld;
  assign pc_inc   = ctrl_q.pc_inc;
  assign ir_ld    = ctrl_q.ir_ld;
  assign im_cs    = ctrl_q.im_cs;
  assign im_rd    = ctrl_q.im_rd;
  assign ir_valid = ctrl_q.ir_valid;
  assign busy     = ctrl_q.busy;
  assign pc_sel   = pc_sel_q;
  assign im_wr    = 1'b0;
  assign retired  = retired_q;

endmodule

// File: tb/tb_iu_fetch_ctrl.sv
// tb/tb_iu_fetch_ctrl.sv - self-checking bench for the fetch sequencer
module tb_iu_fetch_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Instance A: MEM_LAT=1, CNT_W=16
  logic        a_reset, a_start, a_halt, a_taken, a_redirect;
  logic [1:0]  a_sel;
  logic        a_pc_ld, a_pc_inc, a_ir_ld, a_im_cs, a_im_rd, a_im_wr, a_ir_valid, a_busy;
  logic [1:0]  a_pc_sel;
  logic [15:0] a_retired;

  // Instance B: MEM_LAT=3, CNT_W=4
  logic        b_reset, b_start, b_halt, b_taken, b_redirect;
  logic [1:0]  b_sel;
  logic        b_pc_ld, b_pc_inc, b_ir_ld, b_im_cs, b_im_rd, b_im_wr, b_ir_valid, b_busy;
  logic [1:0]  b_pc_sel;
  logic [3:0]  b_retired;

  iu_fetch_ctrl #(.MEM_LAT(1), .CNT_W(16)) u_dut_a (
    .clk(clk), .reset(a_reset), .start(a_start), .halt(a_halt), .ir_taken(a_taken),
    .redirect(a_redirect), .redirect_sel(a_sel), .pc_ld(a_pc_ld), .pc_inc(a_pc_inc),
    .pc_sel(a_pc_sel), .ir_ld(a_ir_ld), .im_cs(a_im_cs), .im_rd(a_im_rd), .im_wr(a_im_wr),
    .ir_valid(a_ir_valid), .busy(a_busy), .retired(a_retired)
  );

  iu_fetch_ctrl #(.MEM_LAT(3), .CNT_W(4)) u_dut_b (
    .clk(clk), .reset(b_reset), .start(b_start), .halt(b_halt), .ir_taken(b_taken),
    .redirect(b_redirect), .redirect_sel(b_sel), .pc_ld(b_pc_ld), .pc_inc(b_pc_inc),
    .pc_sel(b_pc_sel), .ir_ld(b_ir_ld), .im_cs(b_im_cs), .im_rd(b_im_rd), .im_wr(b_im_wr),
    .ir_valid(b_ir_valid), .busy(b_busy), .retired(b_retired)
  );

  // Instruction_Unit datapath model for instance A: PC, IR and a small IM
  localparam logic [31:0] PC_IN = 32'h0000_0080;
  logic [31:0] mem [64];
  logic [31:0] pc_m, ir_m;

  always @(posedge clk) begin
    if (a_reset) begin
      pc_m <= 32'h0;
      ir_m <= 32'h0;
    end else begin
      if (a_pc_ld) begin
        case (a_pc_sel)
          2'b01:   pc_m <= {pc_m[31:28], ir_m[25:0], 2'b00};
          2'b10:   pc_m <= pc_m + {{14{ir_m[15]}}, ir_m[15:0], 2'b00};
          default: pc_m <= PC_IN;
        endcase
      end else if (a_pc_inc) begin
        pc_m <= pc_m + 32'd4;
      end
      if (a_ir_ld) ir_m <= mem[pc_m[7:2]];
    end
  end

  // Scoreboard of expected fetch addresses, popped whenever A loads IR
  logic [31:0] sb_q [$];
  logic [31:0] sb_exp;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!a_reset && a_ir_ld) begin
      n_checks++;
      if (sb_q.size() == 0) begin
        n_errors++;
        $display("FAIL fetch_unexpected: ir_ld at pc 0x%0h, expected no fetch", pc_m);
      end else begin
        sb_exp = sb_q.pop_front();
        if (pc_m !== sb_exp) begin
          n_errors++;
          $display("FAIL fetch_addr: got 0x%0h, expected 0x%0h", pc_m, sb_exp);
        end
      end
    end
    check("a_ld_inc_exclusive", {31'b0, a_pc_ld & a_pc_inc}, 32'h0);
    check("a_im_wr", {31'b0, a_im_wr}, 32'h0);
    check("b_ld_inc_exclusive", {31'b0, b_pc_ld & b_pc_inc}, 32'h0);
    check("b_im_wr", {31'b0, b_im_wr}, 32'h0);
  end

  typedef struct {
    logic        redirect;
    logic [1:0]  sel;
    logic        halt;
    logic [31:0] next_pc;
    logic [1:0]  exp_sel;
  } vec_t;
  vec_t rows [8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_a_valid(input int max);
    int n = 0;
    while (!a_ir_valid && n < max) begin tick(); n++; end
    check("a_hold_reached", {31'b0, a_ir_valid}, 32'h1);
  endtask

  task automatic wait_b_valid(input int max);
    int n = 0;
    while (!b_ir_valid && n < max) begin tick(); n++; end
    check("b_hold_reached", {31'b0, b_ir_valid}, 32'h1);
  endtask

  task automatic check_a_quiet(input string name);
    check(name, {23'b0, a_pc_ld, a_pc_inc, a_ir_ld, a_im_cs, a_im_rd, a_im_wr,
                 a_ir_valid, a_busy, a_pc_sel}, 32'h0);
    check({name, "_retired"}, {16'b0, a_retired}, 32'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete, expected finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'(i * 4);
    mem[0]  = 32'h0800_0010;  // jump, imm26=0x10 -> 0x40
    mem[16] = 32'h1000_0003;  // @0x40 branch +3 -> 0x44+12 = 0x50
    mem[21] = 32'h1000_FFFE;  // @0x54 branch -2 -> 0x58-8 = 0x50

    rows[0] = '{1'b1, 2'b01, 1'b0, 32'h40, 2'b01};
    rows[1] = '{1'b1, 2'b10, 1'b0, 32'h50, 2'b10};
    rows[2] = '{1'b0, 2'b00, 1'b0, 32'h54, 2'b00};
    rows[3] = '{1'b1, 2'b10, 1'b0, 32'h50, 2'b10};
    rows[4] = '{1'b1, 2'b11, 1'b0, 32'h80, 2'b00};
    rows[5] = '{1'b1, 2'b00, 1'b0, 32'h80, 2'b00};
    rows[6] = '{1'b0, 2'b00, 1'b0, 32'h84, 2'b00};
    rows[7] = '{1'b0, 2'b00, 1'b1, 32'h00, 2'b00};

    {a_start, a_halt, a_taken, a_redirect, a_sel} = '0;
    {b_start, b_halt, b_taken, b_redirect, b_sel} = '0;
    a_reset = 1'b1;
    b_reset = 1'b1;

    // Reset held with start asserted: everything quiet, then FETCH on first free edge
    a_start = 1'b1;
    tick();
    check_a_quiet("reset_cycle1");
    tick();
    check_a_quiet("reset_cycle2");
    sb_q.push_back(32'h0);
    sb_q.push_back(32'h4);
    sb_q.push_back(32'h8);
    a_reset = 1'b0;
    a_taken = 1'b1;
    tick();
    a_start = 1'b0;
    check("first_fetch_im_cs", {31'b0, a_im_cs}, 32'h1);
    check("first_fetch_im_rd", {31'b0, a_im_rd}, 32'h1);
    check("first_fetch_busy", {31'b0, a_busy}, 32'h1);
    check("first_fetch_ir_ld", {31'b0, a_ir_ld}, 32'h0);

    // ir_taken held high: IR reload every 3 cycles with pc_inc coincident
    for (int c = 2; c <= 9; c++) begin
      tick();
      check("a_ir_ld_cadence", {31'b0, a_ir_ld}, {31'b0, (c % 3 == 2)});
      check("a_pc_inc_with_ir_ld", {31'b0, a_pc_inc}, {31'b0, (c % 3 == 2)});
    end
    tick();
    check("a_retired_3", {16'b0, a_retired}, 32'd3);
    a_taken = 1'b0;
    a_reset = 1'b1;
    tick();
    check_a_quiet("reset_after_run");

    // Table of accept/redirect/halt vectors driven through HOLD
    a_reset = 1'b0;
    a_start = 1'b1;
    sb_q.push_back(32'h0);
    tick();
    a_start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      wait_a_valid(20);
      a_taken    = 1'b1;
      a_redirect = rows[i].redirect;
      a_sel      = rows[i].sel;
      a_halt     = rows[i].halt;
      if (!rows[i].halt) sb_q.push_back(rows[i].next_pc);
      tick();
      {a_taken, a_redirect, a_sel, a_halt} = '0;
      check("row_pc_ld", {31'b0, a_pc_ld}, {31'b0, rows[i].redirect});
      check("row_pc_sel", {30'b0, a_pc_sel}, {30'b0, rows[i].exp_sel});
      check("row_pc_inc", {31'b0, a_pc_inc}, 32'h0);
      check("row_ir_valid_drop", {31'b0, a_ir_valid}, 32'h0);
      if (rows[i].halt) begin
        check("row_halt_busy", {31'b0, a_busy}, 32'h0);
        check("row_retired", {16'b0, a_retired}, 32'(i + 1));
      end
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      check("a_idle_no_cs", {31'b0, a_im_cs}, 32'h0);
    end
    check("scoreboard_drained", 32'(sb_q.size()), 32'h0);

    // MEM_LAT=3: three read cycles before the IR load cycle
    b_reset = 1'b0;
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    begin
      int cnt = 0;
      while (b_im_rd && !b_ir_ld && cnt < 10) begin cnt++; tick(); end
      check("b_rd_cycles_before_ld", 32'(cnt), 32'd3);
    end
    check("b_ir_ld", {31'b0, b_ir_ld}, 32'h1);
    check("b_im_rd_in_load", {31'b0, b_im_rd}, 32'h1);

    // Halt pulsed in WAIT: the instruction is still presented and must be accepted
    wait_b_valid(20);
    b_taken = 1'b1;
    tick();
    b_taken = 1'b0;
    tick();
    b_halt = 1'b1;
    tick();
    b_halt = 1'b0;
    wait_b_valid(20);
    tick();
    tick();
    check("b_hold_kept", {31'b0, b_ir_valid}, 32'h1);
    b_taken = 1'b1;
    tick();
    b_taken = 1'b0;
    check("b_halt_busy", {31'b0, b_busy}, 32'h0);
    check("b_halt_ir_valid", {31'b0, b_ir_valid}, 32'h0);
    for (int k = 0; k < 5; k++) begin
      tick();
      check("b_halt_no_cs", {31'b0, b_im_cs}, 32'h0);
    end
    check("b_retired_2", {28'b0, b_retired}, 32'd2);

    // CNT_W=4 wrap after 17 accepts, then reset landing in LOAD
    b_reset = 1'b1;
    tick();
    b_reset = 1'b0;
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    for (int i = 0; i < 17; i++) begin
      wait_b_valid(20);
      b_taken = 1'b1;
      tick();
      b_taken = 1'b0;
    end
    check("b_retired_wrap", {28'b0, b_retired}, 32'd1);
    begin
      int n = 0;
      while (!b_ir_ld && n < 10) begin tick(); n++; end
      check("b_reached_load", {31'b0, b_ir_ld}, 32'h1);
    end
    b_reset = 1'b1;
    tick();
    check("b_reset_ir_ld", {31'b0, b_ir_ld}, 32'h0);
    check("b_reset_busy", {31'b0, b_busy}, 32'h0);
    check("b_reset_im_cs", {31'b0, b_im_cs}, 32'h0);
    check("b_reset_retired", {28'b0, b_retired}, 32'h0);
    b_reset = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
